// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL lock / reset sequencer.
// Holds the sequencer state enum, default timing constants and a max helper.
package pll_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with async active-low reset, flops clear to 0.
// Ports: clk, rst_n, d (async input), q (synchronized output).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset / lock-qualification sequencer on the PLL reference clock.
// In: clk, rst_n, pll_locked (async), sw_relock. Out: pll_rst, sys_rst_n,
// ready, relock_count[7:0] (saturating), timeout_err (sticky).
module pll_lock_reset_seq
  import pll_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  localparam int CNT_MAX = max3(
    PLL_RST_CYCLES,
    LOCK_STABLE_CYCLES,
    LOCK_TIMEOUT_CYCLES
  );
  localparam int CW = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] RST_LAST =
    CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock_s counts as stable
  // cycle one, so STABILIZE itself covers the remaining ones.
  localparam logic [CW-1:0] STB_LAST =
    (LOCK_STABLE_CYCLES > 1) ?
    CW'(LOCK_STABLE_CYCLES - 2) : '0;

  logic          lock_s;
  pll_state_e    state;
  pll_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          timeout_hit;
  logic          lock_loss;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CW'(1);
    timeout_hit = 1'b0;
    lock_loss   = 1'b0;
    unique case (state)
      PLL_RESET: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABILIZE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          state_nxt   = PLL_RESET;
          cnt_nxt     = '0;
          timeout_hit = 1'b1;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STB_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = PLL_RESET;
          lock_loss = 1'b1;
        end
      end
      default: begin
        state_nxt = PLL_RESET;
        cnt_nxt   = '0;
      end
    endcase
    // Software relock wins the transition but a coincident
    // lock loss in RUN is still counted via lock_loss.
    if (sw_relock) begin
      state_nxt = PLL_RESET;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      relock_count <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pll_rst   <= (state_nxt == PLL_RESET);
      sys_rst_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
      if (lock_loss && (relock_count != 8'hFF)) begin
        relock_count <= relock_count + 8'd1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed + randomized bench for pll_lock_reset_seq.
// Expectations come from timing rules: widths, latencies, saturating counts.
module tb_pll_lock_reset_seq;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTC = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_relock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] relock_count;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;
  int rst_rises = 0;
  int drops = 0;
  logic pll_rst_d = 1'b0;

  always #5 clk = ~clk;

  pll_lock_reset_seq #(
    .PLL_RST_CYCLES      (PRC),
    .LOCK_STABLE_CYCLES  (LSC),
    .LOCK_TIMEOUT_CYCLES (LTC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .sw_relock    (sw_relock),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_err  (timeout_err)
  );

  // Count pll_rst pulses (entries into the PLL reset phase).
  always @(negedge clk) begin
    if (pll_rst === 1'b1 && pll_rst_d !== 1'b1) rst_rises++;
    pll_rst_d = pll_rst;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic int sat8(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return pll_rst;
      1:       return sys_rst_n;
      2:       return ready;
      default: return timeout_err;
    endcase
  endfunction

  // Ticks until signal reaches val; -1 if the budget expires.
  task automatic wait_sig(
    input  int   which,
    input  logic val,
    input  int   budget,
    output int   n
  );
    n = 0;
    while (sig(which) !== val && n < budget) begin
      tick();
      n++;
    end
    if (sig(which) !== val) n = -1;
  endtask

  // Number of samples pll_rst stays high, from the current one.
  task automatic count_high(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  // From the first pll_rst sample: check pulse width, lock after a
  // random delay, and require release 2 sync + LSC cycles later.
  task automatic relock_from_reset(input string tag);
    int n;
    int unsigned d;
    pll_locked = 1'b0;
    count_high(n);
    chk({tag, " pll_rst width"}, n, PRC);
    d = $urandom_range(1, 20);
    repeat (d) tick();
    pll_locked = 1'b1;
    wait_sig(1, 1'b1, 100, n);
    chk({tag, " release latency"}, n, 2 + LSC);
    chk({tag, " ready"}, ready, 1);
  endtask

  task automatic sw_pulse();
    sw_relock = 1'b1;
    tick();
    sw_relock = 1'b0;
  endtask

  initial begin
    int n;
    int r0;
    int unsigned k;
    int unsigned g;

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    sw_relock  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst pll_rst", pll_rst, 1);
    chk("rst sys_rst_n", sys_rst_n, 0);
    chk("rst ready", ready, 0);
    chk("rst relock_count", relock_count, 0);
    chk("rst timeout_err", timeout_err, 0);

    // Power-up: lock rises 10 cycles after pll_rst falls.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_high(n);
    chk("boot pll_rst width", n, PRC);
    repeat (10) tick();
    pll_locked = 1'b1;
    wait_sig(1, 1'b1, 100, n);
    chk("boot release latency", n, 2 + LSC);
    chk("boot ready", ready, 1);
    chk("boot timeout_err", timeout_err, 0);
    chk("boot relock_count", relock_count, 0);

    // Software relock in RUN: one entry, no count.
    r0 = rst_rises;
    k = $urandom_range(0, 5);
    repeat (k) tick();
    sw_pulse();
    chk("sw pll_rst next", pll_rst, 1);
    chk("sw sys_rst_n next", sys_rst_n, 0);
    relock_from_reset("sw");
    chk("sw entries", rst_rises - r0, 1);
    chk("sw relock_count", relock_count, sat8(drops));

    // Software relock coincident with synced lock loss.
    r0 = rst_rises;
    pll_locked = 1'b0;
    drops++;
    tick();
    tick();
    sw_pulse();
    chk("combo sys_rst_n", sys_rst_n, 0);
    chk("combo pll_rst", pll_rst, 1);
    relock_from_reset("combo");
    chk("combo entries", rst_rises - r0, 1);
    chk("combo relock_count", relock_count, sat8(drops));

    // Lock glitch during stabilize: first at count 5, then random.
    for (int t = 0; t < 2; t++) begin
      sw_pulse();
      pll_locked = 1'b0;
      count_high(n);
      chk("glitch pll_rst width", n, PRC);
      k = $urandom_range(1, 20);
      repeat (k) tick();
      pll_locked = 1'b1;
      r0 = rst_rises;
      g = (t == 0) ? 6 : $urandom_range(1, 7);
      repeat (g) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_sig(1, 1'b1, 100, n);
      chk("glitch release latency", n, 2 + LSC);
      chk("glitch no pll_rst", rst_rises - r0, 0);
      chk("glitch relock_count", relock_count, sat8(drops));
    end

    // Relock request while in reset restarts the count,
    // then lock held low until timeout.
    r0 = rst_rises;
    sw_pulse();
    pll_locked = 1'b0;
    tick();
    sw_pulse();
    count_high(n);
    chk("restart pll_rst width", n, PRC);
    chk("pre timeout_err", timeout_err, 0);
    wait_sig(3, 1'b1, 200, n);
    chk("timeout latency", n, LTC);
    chk("timeout pll_rst", pll_rst, 1);
    relock_from_reset("timeout");
    chk("timeout sticky", timeout_err, 1);
    chk("timeout entries", rst_rises - r0, 2);

    // Repeated lock loss in RUN with saturating count.
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 3);
      repeat (k) tick();
      pll_locked = 1'b0;
      drops++;
      wait_sig(1, 1'b0, 20, n);
      chk("drop sys_rst_n latency", n, 3);
      chk("drop ready", ready, 0);
      relock_from_reset("drop");
      chk("drop relock_count", relock_count, sat8(drops));
    end
    chk("relock saturated", relock_count, 255);

    // Async reset mid-stabilize, between clock edges.
    sw_pulse();
    pll_locked = 1'b0;
    count_high(n);
    k = $urandom_range(1, 20);
    repeat (k) tick();
    pll_locked = 1'b1;
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async pll_rst", pll_rst, 1);
    chk("async sys_rst_n", sys_rst_n, 0);
    chk("async ready", ready, 0);
    chk("async relock_count", relock_count, 0);
    chk("async timeout_err", timeout_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    relock_from_reset("post reset");

    // Async reset in RUN drops outputs at once.
    #2;
    rst_n = 1'b0;
    #1;
    chk("run reset sys_rst_n", sys_rst_n, 0);
    chk("run reset ready", ready, 0);
    chk("run reset pll_rst", pll_rst, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
